// File: rtl/store_buffer_unit.sv
// Store buffer for the MEM stage: legality check, byte-lane steering and an
// in-order FIFO of word-aligned writes drained to data memory by valid/ready.
module store_buffer_unit #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32,
    parameter int DEPTH         = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_MemWriteM,
    input  logic [2:0]                 i_MemDataSelM,
    input  logic [ADDRESS_WIDTH-1:0]   i_ALUOutM,
    input  logic [DATA_WIDTH-1:0]      i_WriteDataM,
    output logic                       o_StallStore,
    output logic                       o_AlignErr,
    output logic                       o_Empty,
    output logic [$clog2(DEPTH):0]     o_Count,
    output logic                       o_MemReqValid,
    input  logic                       i_MemReqReady,
    output logic [ADDRESS_WIDTH-1:0]   o_MemAddr,
    output logic [DATA_WIDTH-1:0]      o_MemWData,
    output logic [3:0]                 o_MemByteEn
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int LANES = 4;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic is_word;
    logic is_half;
    logic is_byte;
    logic req_legal;

    always_comb begin
        is_word = 1'b0;
        is_half = 1'b0;
        is_byte = 1'b0;
        unique case (i_MemDataSelM)
            3'd0:       is_word = 1'b1;
            3'd1, 3'd2: is_half = 1'b1;
            3'd3, 3'd4: is_byte = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        req_legal = 1'b0;
        if (is_word)
            req_legal = (i_ALUOutM[1:0] == 2'b00);
        else if (is_half)
            req_legal = (i_ALUOutM[0] == 1'b0);
        else if (is_byte)
            req_legal = 1'b1;
    end

    // ------------------------------------------------------------------
    // Lane steering: narrow data is replicated across the word so the
    // byte enables alone decide which lanes memory actually writes.
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0]    steer_data;
    logic [LANES-1:0]         steer_be;
    logic [ADDRESS_WIDTH-1:0] word_addr;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            localparam logic       HI_HALF  = (gi >= 2);
            localparam logic [1:0] LANE_IDX = 2'(gi);

            always_comb begin
                if (is_word)
                    steer_data[8*gi +: 8] = i_WriteDataM[8*gi +: 8];
                else if (is_half)
                    steer_data[8*gi +: 8] = i_WriteDataM[8*(gi%2) +: 8];
                else
                    steer_data[8*gi +: 8] = i_WriteDataM[7:0];
            end

            assign steer_be[gi] = is_word
                                | (is_half & (i_ALUOutM[1] == HI_HALF))
                                | (is_byte & (i_ALUOutM[1:0] == LANE_IDX));
        end
    endgenerate

    assign word_addr = {i_ALUOutM[ADDRESS_WIDTH-1:2], 2'b00};

    // ------------------------------------------------------------------
    // FIFO control
    // ------------------------------------------------------------------
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             align_err_q, align_err_d;
    logic             empty;
    logic             full;
    logic             enq;
    logic             deq;

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(DEPTH));

    // Full blocks enqueue even when the head drains this same cycle.
    assign enq = i_MemWriteM & req_legal & ~full;
    assign deq = ~empty & i_MemReqReady;

    always_comb begin
        wr_ptr_d    = enq ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d    = deq ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        align_err_d = i_MemWriteM & ~req_legal;
        count_d     = count_q;
        unique case ({enq, deq})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            align_err_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            align_err_q <= align_err_d;
        end
    end

    // ------------------------------------------------------------------
    // Entry storage. The head is read asynchronously so an entry written
    // into an empty buffer is presented immediately after its write edge.
    // ------------------------------------------------------------------
    logic [ADDRESS_WIDTH-1:0] addr_mem [DEPTH];
    logic [DATA_WIDTH-1:0]    data_mem [DEPTH];
    logic [LANES-1:0]         be_mem   [DEPTH];

    always_ff @(posedge clk) begin
        if (enq) begin
            addr_mem[wr_ptr_q] <= word_addr;
            data_mem[wr_ptr_q] <= steer_data;
            be_mem[wr_ptr_q]   <= steer_be;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign o_StallStore  = i_MemWriteM & full;
    assign o_AlignErr    = align_err_q;
    assign o_Empty       = empty;
    assign o_Count       = count_q;
    assign o_MemReqValid = ~empty;

    // Head fields are forced to zero when empty so stale RAM never leaks out.
    assign o_MemAddr   = empty ? '0 : addr_mem[rd_ptr_q];
    assign o_MemWData  = empty ? '0 : data_mem[rd_ptr_q];
    assign o_MemByteEn = empty ? '0 : be_mem[rd_ptr_q];

endmodule

// File: tb/tb_store_buffer_unit.sv
// Bench for store_buffer_unit: table of single-store vectors plus hand-written
// fill/stall, concurrent enqueue/dequeue, pointer-wrap and mid-run reset sequences.
module tb_store_buffer_unit;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_MemWriteM;
    logic [2:0]  i_MemDataSelM;
    logic [31:0] i_ALUOutM;
    logic [31:0] i_WriteDataM;
    logic        o_StallStore;
    logic        o_AlignErr;
    logic        o_Empty;
    logic [2:0]  o_Count;
    logic        o_MemReqValid;
    logic        i_MemReqReady;
    logic [31:0] o_MemAddr;
    logic [31:0] o_MemWData;
    logic [3:0]  o_MemByteEn;

    store_buffer_unit #(.DATA_WIDTH(32), .ADDRESS_WIDTH(32), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .i_MemWriteM   (i_MemWriteM),
        .i_MemDataSelM (i_MemDataSelM),
        .i_ALUOutM     (i_ALUOutM),
        .i_WriteDataM  (i_WriteDataM),
        .o_StallStore  (o_StallStore),
        .o_AlignErr    (o_AlignErr),
        .o_Empty       (o_Empty),
        .o_Count       (o_Count),
        .o_MemReqValid (o_MemReqValid),
        .i_MemReqReady (i_MemReqReady),
        .o_MemAddr     (o_MemAddr),
        .o_MemWData    (o_MemWData),
        .o_MemByteEn   (o_MemByteEn)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  sel;
        logic [31:0] addr;
        logic [31:0] data;
        logic        legal;
        logic [31:0] exp_addr;
        logic [31:0] exp_data;
        logic [3:0]  exp_be;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } entry_t;

    localparam int NV = 14;
    vec_t   vec [NV];
    entry_t sb_q [$];
    int     errors = 0;
    int     checks = 0;
    int     m_cnt  = 0;
    logic   m_align = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // One clock of stimulus; the scoreboard pushes on predicted enqueue and
    // pops/compares on each handshake the model predicts.
    task automatic cycle(input logic r, input logic we, input logic [2:0] sel,
                         input logic [31:0] a, input logic [31:0] d, input logic rdy,
                         input logic legal, input logic [31:0] ea, input logic [31:0] ed,
                         input logic [3:0] ebe);
        entry_t e;
        logic   enq;
        logic   deq;
        rst           = r;
        i_MemWriteM   = we;
        i_MemDataSelM = sel;
        i_ALUOutM     = a;
        i_WriteDataM  = d;
        i_MemReqReady = rdy;
        #1;
        check("stall", {31'd0, o_StallStore}, {31'd0, we && (m_cnt == DEPTH)});
        check("valid", {31'd0, o_MemReqValid}, {31'd0, m_cnt > 0});
        check("empty", {31'd0, o_Empty}, {31'd0, m_cnt == 0});
        if (m_cnt == 0) begin
            check("idle_addr", o_MemAddr, 32'h0);
            check("idle_wdata", o_MemWData, 32'h0);
            check("idle_be", {28'd0, o_MemByteEn}, 32'h0);
        end
        deq = !r && rdy && (m_cnt > 0);
        enq = !r && we && legal && (m_cnt < DEPTH);
        if (deq) begin
            e = sb_q.pop_front();
            $display("store addr=0x%08h wdata=0x%08h be=%04b (expect 0x%08h 0x%08h %04b)",
                     o_MemAddr, o_MemWData, o_MemByteEn, e.addr, e.data, e.be);
            check("head_addr", o_MemAddr, e.addr);
            check("head_wdata", o_MemWData, e.data);
            check("head_be", {28'd0, o_MemByteEn}, {28'd0, e.be});
        end
        if (r) begin
            sb_q.delete();
            m_cnt   = 0;
            m_align = 1'b0;
        end else begin
            if (enq) begin
                e.addr = ea;
                e.data = ed;
                e.be   = ebe;
                sb_q.push_back(e);
            end
            m_cnt   = m_cnt + (enq ? 1 : 0) - (deq ? 1 : 0);
            m_align = we && !legal;
        end
        @(posedge clk);
        #1;
        check("count", {29'd0, o_Count}, 32'(m_cnt));
        check("align_err", {31'd0, o_AlignErr}, {31'd0, m_align});
    endtask

    task automatic idle(input logic rdy);
        cycle(1'b0, 1'b0, 3'd0, 32'h0, 32'h0, rdy, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    task automatic sw(input logic [31:0] a, input logic [31:0] d, input logic rdy);
        cycle(1'b0, 1'b1, 3'd0, a, d, rdy, 1'b1, a, d, 4'hF);
    endtask

    task automatic drain();
        for (int k = 0; k < 20; k++) begin
            if (m_cnt == 0) break;
            idle(1'b1);
        end
        check("drained", {31'd0, o_Empty}, 32'd1);
    endtask

    initial begin
        vec[0]  = '{3'd0, 32'h0000_0100, 32'hDEAD_BEEF, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'b1111};
        vec[1]  = '{3'd3, 32'h0000_0203, 32'h0000_00A5, 1'b1, 32'h0000_0200, 32'hA5A5_A5A5, 4'b1000};
        vec[2]  = '{3'd2, 32'h0000_0302, 32'h0000_1234, 1'b1, 32'h0000_0300, 32'h1234_1234, 4'b1100};
        vec[3]  = '{3'd1, 32'h0000_0300, 32'hFFFF_5678, 1'b1, 32'h0000_0300, 32'h5678_5678, 4'b0011};
        vec[4]  = '{3'd4, 32'h0000_0401, 32'h1234_5677, 1'b1, 32'h0000_0400, 32'h7777_7777, 4'b0010};
        vec[5]  = '{3'd3, 32'h0000_0400, 32'h0000_003C, 1'b1, 32'h0000_0400, 32'h3C3C_3C3C, 4'b0001};
        vec[6]  = '{3'd4, 32'h0000_0402, 32'h0000_00FE, 1'b1, 32'h0000_0400, 32'hFEFE_FEFE, 4'b0100};
        vec[7]  = '{3'd0, 32'h0000_0102, 32'h1111_1111, 1'b0, 32'h0, 32'h0, 4'b0000};
        vec[8]  = '{3'd1, 32'h0000_0101, 32'h2222_2222, 1'b0, 32'h0, 32'h0, 4'b0000};
        vec[9]  = '{3'd6, 32'h0000_0100, 32'h3333_3333, 1'b0, 32'h0, 32'h0, 4'b0000};
        vec[10] = '{3'd5, 32'h0000_0000, 32'h4444_4444, 1'b0, 32'h0, 32'h0, 4'b0000};
        vec[11] = '{3'd7, 32'h0000_0004, 32'h5555_5555, 1'b0, 32'h0, 32'h0, 4'b0000};
        vec[12] = '{3'd2, 32'h0000_0303, 32'h6666_6666, 1'b0, 32'h0, 32'h0, 4'b0000};
        vec[13] = '{3'd0, 32'hFFFF_FFFC, 32'h0000_0000, 1'b1, 32'hFFFF_FFFC, 32'h0000_0000, 4'b1111};

        rst = 1'b1;
        i_MemWriteM = 1'b0;
        i_MemDataSelM = 3'd0;
        i_ALUOutM = 32'h0;
        i_WriteDataM = 32'h0;
        i_MemReqReady = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_count", {29'd0, o_Count}, 32'd0);
        check("rst_empty", {31'd0, o_Empty}, 32'd1);
        check("rst_valid", {31'd0, o_MemReqValid}, 32'd0);
        check("rst_align", {31'd0, o_AlignErr}, 32'd0);
        rst = 1'b0;

        // Single-store vectors: store, then one cycle to drain, one to see AlignErr fall.
        for (int i = 0; i < NV; i++) begin
            cycle(1'b0, 1'b1, vec[i].sel, vec[i].addr, vec[i].data, 1'b1, vec[i].legal,
                  vec[i].exp_addr, vec[i].exp_data, vec[i].exp_be);
            idle(1'b1);
            idle(1'b1);
        end

        // Fill with memory stalled; fifth store stalls until a slot frees.
        for (int i = 0; i < 4; i++) sw(32'(4 * i), 32'hA000_0000 | 32'(4 * i), 1'b0);
        sw(32'h10, 32'hA000_0010, 1'b0);
        for (int k = 0; k < 8; k++) begin
            automatic bit accepted = (m_cnt < DEPTH);
            sw(32'h10, 32'hA000_0010, 1'b1);
            if (accepted) break;
        end
        drain();

        // Concurrent enqueue/dequeue at count 2, then full with concurrent dequeue.
        sw(32'h20, 32'hB000_0020, 1'b0);
        sw(32'h24, 32'hB000_0024, 1'b0);
        sw(32'h28, 32'hB000_0028, 1'b1);
        check("count_hold", {29'd0, o_Count}, 32'd2);
        sw(32'h2C, 32'hB000_002C, 1'b0);
        sw(32'h30, 32'hB000_0030, 1'b0);
        sw(32'h34, 32'hB000_0034, 1'b1);
        check("full_deq_no_enq", {29'd0, o_Count}, 32'd3);
        drain();

        // Ten stores with intermittent ready so both pointers wrap.
        for (int i = 0; i < 10; i++)
            sw(32'h1000 + 32'(4 * i), 32'hC000_0000 + 32'(i), (i % 3) != 2);
        drain();

        // Reset with three entries pending, then normal operation resumes.
        for (int i = 0; i < 3; i++) sw(32'h500 + 32'(4 * i), 32'hD000_0000 + 32'(i), 1'b0);
        cycle(1'b1, 1'b0, 3'd0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        check("mid_rst_be", {28'd0, o_MemByteEn}, 32'd0);
        check("mid_rst_valid", {31'd0, o_MemReqValid}, 32'd0);
        sw(32'h40, 32'hE000_0040, 1'b1);
        idle(1'b1);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
